// File: rtl/spi_slave_burst.sv
// -----------------------------------------------------------------------------
// spi_slave_burst
//
// SPI slave front end for the RAM wrapper. SCLK is the system clock, so one
// serial bit moves per rising edge of clk, MSB first. Incoming MOSI frames are
// {cmd[1:0], payload[DATA_W-1:0]} and are presented on rx_data with a one-clock
// rx_valid pulse. Read words returned by the RAM (tx_data/tx_valid) are
// serialised onto MISO.
//
// Build option:
//   SPI_SLAVE_BURST_EN  when defined, a READ_DATA transaction keeps streaming
//                       words while SS_n stays low, requesting each following
//                       word with a one-clock next_req pulse. When undefined,
//                       exactly one word is returned per READ_DATA frame and
//                       next_req is tied low.
//
// Ports:
//   clk        in   system clock / SCLK, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   SS_n       in   slave select, active low
//   MOSI       in   serial data in
//   tx_valid   in   tx_data holds a RAM read word
//   tx_data    in   read word to shift out on MISO
//   rx_data    out  captured frame {cmd, payload}
//   rx_valid   out  one-clock pulse, rx_data holds a complete frame
//   MISO       out  serial data out
//   frame_err  out  one-clock pulse, SS_n rose before a full frame arrived
//   next_req   out  one-clock pulse, request the next burst word
// -----------------------------------------------------------------------------
module spi_slave_burst #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W + 3)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              SS_n,
   input  logic              MOSI,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   output logic              MISO,
   output logic              frame_err,
   output logic              next_req
);

   localparam int FRAME_W = DATA_W + 2;

   // cnt_q runs 0..FRAME_W while bits arrive, sits at CNT_FULL for the one clock
   // that raises rx_valid, then parks at CNT_DONE for the rest of the frame.
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_W + 1);
   localparam logic [CNT_W-1:0] TX_BITS  = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_e;

   typedef enum logic [1:0] {
      TX_WAIT,
      TX_SHIFT,
      TX_NEXT,
      TX_DONE
   } tx_phase_e;

   state_e              state_q;
   tx_phase_e           txPhase_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    txCnt_q;
   logic [DATA_W-1:0]   txShift_q;
   logic [FRAME_W-1:0]  rxData_q;
   logic                rxValid_q;
   logic                frameErr_q;
   logic                miso_q;
   logic                rdAddrSeen_q;
   logic [CNT_W-1:0]    bitIdx;
`ifdef SPI_SLAVE_BURST_EN
   logic                nextReq_q;
   logic                wordSent_q;
`endif

   // Bits arrive MSB first, so the first captured bit lands in the top slot.
   assign bitIdx = CNT_TOP - cnt_q;

   // Whole slave in one clocked process. SS_n high overrides every state: the
   // transaction ends, counters clear and MISO returns low. A frame_err is only
   // raised while bits are still being collected; once the frame is complete
   // (including during MISO shifting) a deselect is a normal end.
   // rd_addr_seen remembers that a READ_ADD frame completed so that the next
   // read command frame is routed to READ_DATA.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         txPhase_q    <= TX_WAIT;
         cnt_q        <= '0;
         txCnt_q      <= '0;
         txShift_q    <= '0;
         rxData_q     <= '0;
         rxValid_q    <= 1'b0;
         frameErr_q   <= 1'b0;
         miso_q       <= 1'b0;
         rdAddrSeen_q <= 1'b0;
`ifdef SPI_SLAVE_BURST_EN
         nextReq_q    <= 1'b0;
         wordSent_q   <= 1'b0;
`endif
      end else begin
         rxValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
`ifdef SPI_SLAVE_BURST_EN
         nextReq_q  <= 1'b0;
`endif
         if (SS_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            txCnt_q   <= '0;
            txPhase_q <= TX_WAIT;
            miso_q    <= 1'b0;
            if ((state_q == WRITE || state_q == READ_ADD || state_q == READ_DATA) &&
                (cnt_q < CNT_FULL)) begin
               frameErr_q <= 1'b1;
            end
`ifdef SPI_SLAVE_BURST_EN
            wordSent_q <= 1'b0;
            if (state_q == READ_DATA && wordSent_q) begin
               rdAddrSeen_q <= 1'b0;
            end
`endif
         end else begin
            case (state_q)
               IDLE: begin
                  miso_q  <= 1'b0;
                  state_q <= CHK_CMD;
               end
               CHK_CMD: begin
                  if (!MOSI) begin
                     state_q <= WRITE;
                  end else if (rdAddrSeen_q) begin
                     state_q <= READ_DATA;
                  end else begin
                     state_q <= READ_ADD;
                  end
               end
               default: begin
                  if (cnt_q < CNT_FULL) begin
                     rxData_q[bitIdx] <= MOSI;
                     cnt_q            <= cnt_q + CNT_ONE;
                  end else if (cnt_q == CNT_FULL) begin
                     rxValid_q <= 1'b1;
                     cnt_q     <= CNT_DONE;
                     if (state_q == READ_ADD) begin
                        rdAddrSeen_q <= 1'b1;
                     end
                  end else if (state_q == READ_DATA) begin
                     case (txPhase_q)
                        TX_WAIT: begin
                           miso_q <= 1'b0;
                           if (tx_valid) begin
                              txShift_q <= tx_data;
                              txCnt_q   <= TX_BITS;
                              txPhase_q <= TX_SHIFT;
                           end
                        end
                        TX_SHIFT: begin
                           miso_q    <= txShift_q[DATA_W-1];
                           txShift_q <= {txShift_q[DATA_W-2:0], 1'b0};
                           txCnt_q   <= txCnt_q - CNT_ONE;
                           if (txCnt_q == CNT_ONE) begin
`ifdef SPI_SLAVE_BURST_EN
                              wordSent_q <= 1'b1;
                              txPhase_q  <= TX_NEXT;
`else
                              rdAddrSeen_q <= 1'b0;
                              txPhase_q    <= TX_DONE;
`endif
                           end
                        end
`ifdef SPI_SLAVE_BURST_EN
                        TX_NEXT: begin
                           miso_q    <= 1'b0;
                           nextReq_q <= 1'b1;
                           txPhase_q <= TX_WAIT;
                        end
`endif
                        default: begin
                           miso_q <= 1'b0;
                        end
                     endcase
                  end
               end
            endcase
         end
      end
   end

   // Every output comes straight from a register.
   assign rx_data   = rxData_q;
   assign rx_valid  = rxValid_q;
   assign MISO      = miso_q;
   assign frame_err = frameErr_q;
`ifdef SPI_SLAVE_BURST_EN
   assign next_req  = nextReq_q;
`else
   assign next_req  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_burst.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_burst
//
// Directed bench for spi_slave_burst (DATA_W = 8). Stimulus tasks drive one
// clock at a time and push the hand-derived output vector expected after that
// edge into a queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_spi_slave_burst;

   localparam int DATA_W = 8;
`ifdef SPI_SLAVE_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   typedef struct packed {
      logic       rxv;
      logic       err;
      logic       req;
      logic       miso;
      logic       chkRxd;
      logic [9:0] rxd;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              SS_n;
   logic              MOSI;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W+1:0] rx_data;
   logic              rx_valid;
   logic              MISO;
   logic              frame_err;
   logic              next_req;

   exp_t  expQ[$];
   string tagQ[$];
   int    total = 0;
   int    bad   = 0;
   exp_t  monE;
   string monT;

   spi_slave_burst #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .MISO      (MISO),
      .frame_err (frame_err),
      .next_req  (next_req)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Compare one output vector against its expectation.
   task automatic checkOutput(input exp_t e, input string tag);
      logic [3:0] act;
      logic [3:0] want;
      act  = {rx_valid, frame_err, next_req, MISO};
      want = {e.rxv, e.err, e.req, e.miso};
      total++;
      if (act !== want || (e.chkRxd && rx_data !== e.rxd)) begin
         bad++;
         $display("[TB] FAIL %s: got rxv/err/req/miso=%b rx_data=%h, want %b rx_data=%h",
                  tag, act, rx_data, want, e.rxd);
      end
   endtask

   // Monitor: each falling edge, settle one pending expectation.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monE = expQ.pop_front();
         monT = tagQ.pop_front();
         checkOutput(monE, monT);
      end
   end

   // Drive one clock of inputs and queue the outputs expected after that edge.
   task automatic applyStimulus(input logic r, input logic ssn, input logic mosi,
                                input logic txv, input logic [7:0] txd,
                                input exp_t e, input string tag);
      rst      = r;
      SS_n     = ssn;
      MOSI     = mosi;
      tx_valid = txv;
      tx_data  = txd;
      @(posedge clk);
      expQ.push_back(e);
      tagQ.push_back(tag);
      #1;
   endtask

   // Full frame from IDLE: select edge, routing bit, 10 data bits, rx_valid edge.
   task automatic sendFrame(input logic route, input logic [9:0] frame,
                            input logic earlyTx, input string tag);
      exp_t e;
      e = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e, {tag, " sel"});
      applyStimulus(1'b0, 1'b0, route, 1'b0, 8'h00, e, {tag, " route"});
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, frame[9-i], earlyTx, 8'hFF, e,
                       $sformatf("%s bit%0d", tag, i));
      end
      e.rxv    = 1'b1;
      e.chkRxd = 1'b1;
      e.rxd    = frame;
      applyStimulus(1'b0, 1'b0, 1'b0, earlyTx, 8'hFF, e, {tag, " rx_valid"});
   endtask

   // SS_n high for n clocks, optionally checking rx_data holds.
   task automatic idle(input int n, input logic chk, input logic [9:0] rxd, input string tag);
      exp_t e;
      e        = '0;
      e.chkRxd = chk;
      e.rxd    = rxd;
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, e, tag);
      end
   endtask

   // Eight MISO bits, MSB first; en=0 expects MISO to stay low instead.
   task automatic expectWord(input logic [7:0] word, input int noiseAt,
                             input logic en, input string tag);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e      = '0;
         e.miso = en & word[7-i];
         applyStimulus(1'b0, 1'b0, 1'b0, (i == noiseAt), 8'h00, e,
                       $sformatf("%s b%0d", tag, i));
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      exp_t z;
      exp_t e;
      z = '0;
      rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;

      // Reset: everything low, rx_data cleared.
      e = '0; e.chkRxd = 1'b1;
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, e, "reset");

      // Write frame 00_1010_0101.
      sendFrame(1'b0, 10'h0A5, 1'b0, "write");
      idle(1, 1'b1, 10'h0A5, "write end");

      // Read pair: address frame, then data frame with early tx_valid ignored.
      sendFrame(1'b1, 10'h203, 1'b0, "rdadd");
      idle(1, 1'b1, 10'h203, "rdadd end");
      sendFrame(1'b1, 10'h300, 1'b1, "rddata");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "rd wait");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, z, "rd load");
      expectWord(8'hC3, 2, 1'b1, "rd C3");
      e = '0; e.req = BURST;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e, "rd after");
      idle(1, 1'b0, 10'h000, "rd end");

      // rd_addr_seen cleared: a read command now routes to READ_ADD.
      sendFrame(1'b1, 10'h205, 1'b0, "seen clr");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, z, "rdadd txv");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "rdadd quiet");
      idle(1, 1'b0, 10'h000, "seen clr end");

      // Burst: 8'h11 then 8'h22 with SS_n held low.
      sendFrame(1'b1, 10'h300, 1'b0, "burst");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, z, "burst load1");
      expectWord(8'h11, -1, 1'b1, "burst w1");
      e = '0; e.req = BURST;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e, "burst req1");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, z, "burst load2");
      expectWord(8'h22, -1, BURST, "burst w2");
      e = '0; e.req = BURST;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, e, "burst req2");
      idle(1, 1'b0, 10'h000, "burst end");

      // Abort after 5 WRITE bits, then a normal frame.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "abort sel");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "abort route");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, z, $sformatf("abort bit%0d", i));
      end
      e = '0; e.err = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, e, "abort err");
      idle(1, 1'b0, 10'h000, "abort idle");
      sendFrame(1'b0, 10'h15A, 1'b0, "after abort");
      idle(1, 1'b1, 10'h15A, "after abort end");

      // Deselect in CHK_CMD: no frame_err.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "chk sel");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, z, "chk abort");
      idle(1, 1'b0, 10'h000, "chk idle");

      // Reset mid READ_ADD shift.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "rst sel");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, z, "rst route");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, z, "rst bit0");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "rst bit1");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, z, "rst bit2");
      e = '0; e.chkRxd = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, e, "rst mid");
      idle(1, 1'b1, 10'h000, "rst after");

      // Reset clears rd_addr_seen: address frame, reset, read goes to READ_ADD.
      sendFrame(1'b1, 10'h201, 1'b0, "rst rdadd");
      e = '0; e.chkRxd = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, e, "rst seen");
      idle(1, 1'b1, 10'h000, "rst seen idle");
      sendFrame(1'b1, 10'h3FF, 1'b0, "post rst");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, z, "post rst txv");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, z, "post rst quiet");
      idle(1, 1'b0, 10'h000, "post rst end");

      // Let the monitor settle the last expectation.
      @(negedge clk);
      #1;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
